// File: rtl/spu_pkg.sv
// Shared SPU definitions: datapath width, the LNOP filler encoding and the
// instruction-pair record carried from fetch through the issue buffer.
package spu_pkg;

  localparam int WORD = 32;

  // Encoding placed in an empty slot (misaligned fetch or split issue).
  localparam logic [WORD-1:0] LNOP = 32'h0020_0000;

  typedef struct packed {
    logic [WORD-1:0] pc;
    logic [WORD-1:0] instr1;
    logic [WORD-1:0] instr2;
  } instr_pair_t;

  // Value the storage and outputs show after reset.
  localparam instr_pair_t RESET_PAIR = '{pc: '0, instr1: LNOP, instr2: LNOP};

endpackage

// File: rtl/pair_fifo.sv
// pair_fifo: DEPTH-entry storage of instruction pairs with wrapping
// pointers, an occupancy count and a flush that empties the FIFO at the
// next edge. Flush wins over push and pop. The head entry is read
// combinationally from registers.
module pair_fifo
  import spu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  instr_pair_t                wr_data,
  output instr_pair_t                rd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  instr_pair_t   mem_q [DEPTH];
  instr_pair_t   mem_d [DEPTH];

  // Next-state pointers and count; flush discards every entry.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  // Next-state storage: only the slot under the write pointer changes.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (push && !flush && (wr_ptr_q == PW'(i))) mem_d[i] = wr_data;
    end
  end

  // State registers; storage is cleared so an empty buffer shows LNOPs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_PAIR;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/instr_issue_buffer.sv
// instr_issue_buffer: consumer side of the fetch interface. Buffers fetched
// instruction pairs, back-pressures fetch when full, presents the head pair
// to decode and supports splitting a pair into two single issues (half
// flag). A taken branch flushes all buffered wrong-path pairs.
// Optional: define ISSUE_BUF_BYPASS_EN to present a fetched pair in the
// same cycle when the buffer is empty.
module instr_issue_buffer
  import spu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_valid,
  input  logic [WORD-1:0] fetch_pc,
  input  logic [WORD-1:0] fetch_instr1,
  input  logic [WORD-1:0] fetch_instr2,
  output logic            fetch_stall,
  input  logic            branch_taken,
  input  logic            stop_and_signal,
  input  logic            issue_ready,
  input  logic            issue_one_only,
  output logic            issue_valid,
  output logic [WORD-1:0] issue_pc,
  output logic [WORD-1:0] issue_instr1,
  output logic [WORD-1:0] issue_instr2
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] count;
  logic          half_q, half_d;
  logic          accept;
  logic          handshake;
  logic          consume;
  logic          fifo_push;
  logic          fifo_pop;
  instr_pair_t   fetch_pair;
  instr_pair_t   head_pair;
  instr_pair_t   stored_pair;

  assign fetch_pair = '{pc: fetch_pc, instr1: fetch_instr1, instr2: fetch_instr2};

  // Stall looks only at the registered count, so a same-cycle pop never
  // opens a slot for fetch.
  assign fetch_stall = (count == CW'(DEPTH));
  assign accept      = fetch_valid && !fetch_stall && !branch_taken;

`ifdef ISSUE_BUF_BYPASS_EN
  logic bypass;

  // With an empty buffer the fetch pair goes straight to decode; the half
  // flag is always clear here because it only survives with an entry held.
  assign bypass      = (count == '0) && fetch_valid;
  assign issue_valid = (bypass || (count != '0)) && !stop_and_signal;
  assign head_pair   = bypass ? fetch_pair : stored_pair;
  // A bypassed pair that is fully consumed is never written.
  assign fifo_push   = accept && !(bypass && consume);
  assign fifo_pop    = consume && !bypass && !branch_taken;
`else
  assign issue_valid = (count != '0) && !stop_and_signal;
  assign head_pair   = stored_pair;
  assign fifo_push   = accept;
  assign fifo_pop    = consume && !branch_taken;
`endif

  // A handshake consumes the head unless it is the first half of a split.
  assign handshake = issue_valid && issue_ready;
  assign consume   = handshake && (!issue_one_only || half_q);

  // Half flag: set by a split, cleared by the pop that finishes the pair.
  always_comb begin
    half_d = half_q;
    if (branch_taken)   half_d = 1'b0;
    else if (handshake) half_d = !consume;
  end

  // Half flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) half_q <= 1'b0;
    else       half_q <= half_d;
  end

  pair_fifo #(
    .DEPTH (DEPTH)
  ) u_pair_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (branch_taken),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (fetch_pair),
    .rd_data (stored_pair),
    .count   (count)
  );

  assign issue_pc     = head_pair.pc;
  assign issue_instr1 = half_q ? LNOP : head_pair.instr1;
  assign issue_instr2 = head_pair.instr2;

endmodule

// File: tb/tb_instr_issue_buffer.sv
// Directed bench for instr_issue_buffer (default build, DEPTH = 4).
// Inputs change 1 time unit after a rising edge; outputs are checked one
// further unit later, well away from the next edge.
module tb_instr_issue_buffer;
  import spu_pkg::*;

  localparam logic [31:0] LNOP_V = 32'h0020_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_valid, branch_taken, stop_and_signal, issue_ready, issue_one_only;
  logic [31:0] fetch_pc, fetch_instr1, fetch_instr2;
  logic        fetch_stall, issue_valid;
  logic [31:0] issue_pc, issue_instr1, issue_instr2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_issue_buffer #(.DEPTH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_valid     (fetch_valid),
    .fetch_pc        (fetch_pc),
    .fetch_instr1    (fetch_instr1),
    .fetch_instr2    (fetch_instr2),
    .fetch_stall     (fetch_stall),
    .branch_taken    (branch_taken),
    .stop_and_signal (stop_and_signal),
    .issue_ready     (issue_ready),
    .issue_one_only  (issue_one_only),
    .issue_valid     (issue_valid),
    .issue_pc        (issue_pc),
    .issue_instr1    (issue_instr1),
    .issue_instr2    (issue_instr2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fetch_valid = 0; fetch_pc = 0; fetch_instr1 = 0; fetch_instr2 = 0;
    branch_taken = 0; stop_and_signal = 0; issue_ready = 0; issue_one_only = 0;
  endtask

  // Present one pair for a single edge, then drop fetch_valid.
  task automatic push_pair(input logic [31:0] pc, input logic [31:0] i1, input logic [31:0] i2);
    fetch_valid = 1; fetch_pc = pc; fetch_instr1 = i1; fetch_instr2 = i2;
    step();
    fetch_valid = 0;
    #1;
  endtask

  task automatic test_reset();
    #1;
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", issue_valid); end
    total++; if (fetch_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0b want=0", fetch_stall); end
    total++; if (issue_instr1 !== LNOP_V || issue_instr2 !== LNOP_V || issue_pc !== 32'h0) begin
      bad++; $display("FAIL rst_fields got=%h/%h/%h want=0/%h/%h", issue_pc, issue_instr1, issue_instr2, LNOP_V, LNOP_V); end
    push_pair(32'h100, 32'h1, 32'h2);
    push_pair(32'h108, 32'h3, 32'h4);
    push_pair(32'h110, 32'h5, 32'h6);
    total++; if (issue_valid !== 1'b1 || issue_pc !== 32'h100) begin
      bad++; $display("FAIL pre_rst_head got=%0b/%h want=1/100", issue_valid, issue_pc); end
    reset = 1;
    step();
    reset = 0;
    #1;
    total++; if (issue_valid !== 1'b0 || fetch_stall !== 1'b0) begin
      bad++; $display("FAIL midrst_state got=%0b/%0b want=0/0", issue_valid, fetch_stall); end
    total++; if (issue_instr1 !== LNOP_V || issue_instr2 !== LNOP_V || issue_pc !== 32'h0) begin
      bad++; $display("FAIL midrst_fields got=%h/%h/%h want=0/LNOP/LNOP", issue_pc, issue_instr1, issue_instr2); end
    $display("txn reset done");
  endtask

  task automatic test_fill_drain();
    for (int k = 0; k < 4; k++) push_pair(32'(k * 8), 32'(k * 8 + 1), 32'(k * 8 + 2));
    total++; if (fetch_stall !== 1'b1) begin bad++; $display("FAIL full_stall got=%0b want=1", fetch_stall); end
    push_pair(32'h20, 32'h21, 32'h22);
    total++; if (fetch_stall !== 1'b1 || issue_pc !== 32'h0) begin
      bad++; $display("FAIL fifth_push got=%0b/%h want=1/0", fetch_stall, issue_pc); end
    issue_ready = 1;
    #1;
    for (int k = 0; k < 4; k++) begin
      total++; if (issue_valid !== 1'b1 || issue_pc !== 32'(k * 8) || issue_instr1 !== 32'(k * 8 + 1) || issue_instr2 !== 32'(k * 8 + 2)) begin
        bad++; $display("FAIL drain_%0d got=%0b/%h/%h/%h want=1/%h/%h/%h", k, issue_valid, issue_pc, issue_instr1, issue_instr2, k * 8, k * 8 + 1, k * 8 + 2); end
      $display("txn issue pc=%h", issue_pc);
      step();
    end
    total++; if (issue_valid !== 1'b0 || fetch_stall !== 1'b0) begin
      bad++; $display("FAIL drained got=%0b/%0b want=0/0", issue_valid, fetch_stall); end
    issue_ready = 0;
    #1;
  endtask

  task automatic test_split();
    push_pair(32'h8, 32'hA, 32'hB);
    push_pair(32'h10, 32'hC, 32'hD);
    total++; if (issue_pc !== 32'h8 || issue_instr1 !== 32'hA || issue_instr2 !== 32'hB) begin
      bad++; $display("FAIL split_head got=%h/%h/%h want=8/a/b", issue_pc, issue_instr1, issue_instr2); end
    issue_ready = 1; issue_one_only = 1;
    step();
    total++; if (issue_valid !== 1'b1 || issue_pc !== 32'h8 || issue_instr1 !== LNOP_V || issue_instr2 !== 32'hB) begin
      bad++; $display("FAIL split_half got=%0b/%h/%h/%h want=1/8/%h/b", issue_valid, issue_pc, issue_instr1, issue_instr2, LNOP_V); end
    $display("txn split pc=%h", issue_pc);
    step();
    total++; if (issue_pc !== 32'h10 || issue_instr1 !== 32'hC || issue_instr2 !== 32'hD) begin
      bad++; $display("FAIL split_pop got=%h/%h/%h want=10/c/d", issue_pc, issue_instr1, issue_instr2); end
    issue_one_only = 0;
    step();
    issue_ready = 0;
    #1;
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL split_empty got=%0b want=0", issue_valid); end
  endtask

  task automatic test_flush();
    push_pair(32'h200, 32'h1, 32'h2);
    push_pair(32'h208, 32'h3, 32'h4);
    push_pair(32'h210, 32'h5, 32'h6);
    fetch_valid = 1; fetch_pc = 32'h218; branch_taken = 1;
    step();
    fetch_valid = 0; branch_taken = 0;
    #1;
    total++; if (issue_valid !== 1'b0 || fetch_stall !== 1'b0) begin
      bad++; $display("FAIL flush_empty got=%0b/%0b want=0/0", issue_valid, fetch_stall); end
    fetch_valid = 1; fetch_pc = 32'h40; fetch_instr1 = 32'h41; fetch_instr2 = 32'h42;
    #1;
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL bta_latency got=%0b want=0", issue_valid); end
    step();
    fetch_valid = 0;
    #1;
    total++; if (issue_valid !== 1'b1 || issue_pc !== 32'h40 || issue_instr1 !== 32'h41) begin
      bad++; $display("FAIL bta_head got=%0b/%h/%h want=1/40/41", issue_valid, issue_pc, issue_instr1); end
    $display("txn flush then bta pc=%h", issue_pc);
    issue_ready = 1;
    step();
    issue_ready = 0;
    #1;
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL flush_stale got=%0b want=0", issue_valid); end
  endtask

  task automatic test_stop();
    stop_and_signal = 1; issue_ready = 1;
    for (int k = 0; k < 4; k++) push_pair(32'(32'h300 + k * 8), 32'(k), 32'(k + 16));
    total++; if (fetch_stall !== 1'b1 || issue_valid !== 1'b0) begin
      bad++; $display("FAIL stop_full got=%0b/%0b want=1/0", fetch_stall, issue_valid); end
    stop_and_signal = 0;
    #1;
    for (int k = 0; k < 4; k++) begin
      total++; if (issue_valid !== 1'b1 || issue_pc !== 32'(32'h300 + k * 8)) begin
        bad++; $display("FAIL stop_resume_%0d got=%0b/%h want=1/%h", k, issue_valid, issue_pc, 32'h300 + k * 8); end
      $display("txn resume pc=%h", issue_pc);
      step();
    end
    issue_ready = 0;
    #1;
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL stop_drained got=%0b want=0", issue_valid); end
  endtask

  task automatic test_wrap();
    push_pair(32'h400, 32'h0, 32'h0);
    issue_ready = 1; fetch_valid = 1;
    for (int k = 0; k < 10; k++) begin
      fetch_pc = 32'(32'h400 + (k + 1) * 8);
      #1;
      total++; if (issue_valid !== 1'b1 || issue_pc !== 32'(32'h400 + k * 8) || fetch_stall !== 1'b0) begin
        bad++; $display("FAIL wrap_%0d got=%0b/%h/%0b want=1/%h/0", k, issue_valid, issue_pc, fetch_stall, 32'h400 + k * 8); end
      $display("txn wrap pc=%h", issue_pc);
      step();
    end
    fetch_valid = 0;
    #1;
    total++; if (issue_pc !== 32'h450) begin bad++; $display("FAIL wrap_last got=%h want=450", issue_pc); end
    step();
    issue_ready = 0;
    #1;
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL wrap_empty got=%0b want=0", issue_valid); end
  endtask

  initial begin
    idle();
    step();
    step();
    reset = 0;
    test_reset();
    test_fill_drain();
    test_split();
    test_flush();
    test_stop();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_issue_buffer.md
Name: instr_issue_buffer

Overview:
- Consumer end of the fetch interface. Accepts instruction pairs (PC, instr1, instr2) from the fetch stage into a small pair-FIFO.
- Drives the fetch stall back to fetch and presents the head pair to decode/dependency-check.
- Supports dual-issue or split single-issue. On a taken branch, flushes all buffered wrong-path pairs.

Parameters:
- DEPTH, 4, number of instruction-pair entries; power of 2, at least 2.
- WORD, 32, instruction/PC width; taken from the shared package.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- fetch_valid  in  1  fetch presents a pair this cycle
- fetch_pc  in  WORD  PC of the pair
- fetch_instr1  in  WORD  even-slot instruction (LNOP if the pair was misaligned)
- fetch_instr2  in  WORD  odd-slot instruction
- fetch_stall  out  1  buffer cannot accept; drives both fetch dependency-stall inputs
- branch_taken  in  1  flush request from the branch unit
- stop_and_signal  in  1  halts issue
- issue_ready  in  1  decode accepts the presented pair
- issue_one_only  in  1  decode accepts slot 1 only (dependency/structural hazard on slot 2)
- issue_valid  out  1  head entry presented
- issue_pc  out  WORD  head PC
- issue_instr1  out  WORD  head slot-1 instruction (LNOP after a split)
- issue_instr2  out  WORD  head slot-2 instruction

Behaviour:
- Storage: DEPTH entries of {pc, instr1, instr2}. Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Reset (asynchronous) values:
  - pointers = 0, count = 0, half flag = 0
  - issue_valid = 0, fetch_stall = 0
  - issue_instr1 = issue_instr2 = LNOP (32'h0020_0000), issue_pc = 0
  - A reset asserted mid-operation discards all entries immediately.
- fetch_stall = (count == DEPTH), combinational.
- Push: fetch_valid && !fetch_stall && !branch_taken. The entry is written at the rising edge.
- Issue presentation:
  - issue_valid = (count != 0) && !stop_and_signal.
  - Output fields come from the head entry and are combinational from registers.
  - Latency: one cycle from push to issue_valid.
- Issue handshake, at the edge where issue_valid && issue_ready:
  - If !issue_one_only, or the half flag is already set: pop the head and clear the half flag.
  - If issue_one_only and the half flag is clear: no pop; set the half flag. Subsequent presentations show issue_instr1 = LNOP and issue_instr2 = the stored instr2.
- A simultaneous push and pop leaves count unchanged, and the push is permitted even when full-before-pop is false.
- Because stall is computed from the registered count, a simultaneous pop does not relieve a full buffer in the same cycle.
- branch_taken has priority over push and pop at the edge: pointers, count and half flag go to 0, and the same-cycle fetch pair is dropped.
  - issue_valid is still driven combinationally during the branch_taken cycle. Decode must ignore it.
- stop_and_signal:
  - Blocks pops and half-flag updates.
  - Pushes continue until full.
  - A flush is still honoured.
- No arithmetic on instruction data; the PC is passed through unmodified.

Optional Feature:
- Macro: ISSUE_BUF_BYPASS_EN.
- When defined and the buffer is empty, an accepted fetch pair is presented the same cycle (issue_valid = fetch_valid, outputs muxed from the fetch inputs).
  - If it is also fully issued that cycle, it is not written.
  - If it is split, it is written with the half flag set.
- When not defined, latency is always one cycle, as specified above.

Decomposition:
- Package spu_pkg holds:
  - WORD = 32
  - LNOP constant 32'h0020_0000
  - typedef instr_pair_t {pc, instr1, instr2}
- One natural sub-module: pair_fifo, the parameterised storage with pointers, count and a flush input.
- Split and half-flag logic, stall, and the optional bypass remain in instr_issue_buffer.

Test Plan:
- Reset mid-stream with count = 3 → next cycle: issue_valid = 0, fetch_stall = 0, outputs LNOP.
- Push 4 pairs (PC 0x0, 0x8, 0x10, 0x18) with issue_ready = 0 → fetch_stall = 1. A 5th push (PC 0x20) is ignored. Releasing issue_ready issues 0x0..0x18 in order on consecutive cycles.
- Head PC 0x8, instr1 = 0xA, instr2 = 0xB, with issue_one_only = 1 for one handshake → next cycle: same PC, issue_instr1 = 0x0020_0000, issue_instr2 = 0xB. The next handshake pops.
- Three entries buffered plus fetch_valid in the same cycle as branch_taken → next cycle: count = 0, issue_valid = 0. A push of BTA PC 0x40 appears after one cycle.
- stop_and_signal = 1 with issue_ready = 1 → no pops; the buffer fills to DEPTH and fetch_stall = 1. Deasserting stop_and_signal resumes in order.
- Wrap: 10 interleaved push/pop pairs across the pointer wrap → PCs emerge in order, with no loss or duplication.
